dkong_mem_arbiter: RTL and testbench
====================================

// Module: dkong_mem_arbiter
// PURPOSE
//  Shares one synchronous single-port program/graphics memory between three requesters: ioctl ROM download
//  (absolute priority), main-CPU reads and the hiscore save/restore engine (read/write).
//  Sits between hps_io/dkong_top and the memory. Also generates the game reset that is held across a download.
// PARAMETERS
//  AW           16    address width of every address port
//  MEM_DEPTH    65536 valid locations; download addresses >= MEM_DEPTH are discarded
//  HOLD_CYCLES  16    clk_sys cycles game_reset stays high after dl_active falls (>=1)
// PORTS
//  clk_sys    in   1   system clock; one clock only
//  reset      in   1   synchronous reset, active-high
//  dl_active  in   1   download in progress (ioctl_download)
//  dl_wr      in   1   one-cycle download byte strobe
//  dl_addr    in   AW  download byte address
//  dl_data    in   8   download byte
//  dl_ovf     out  1   sticky: dl_wr arrived while the download buffer was full
//  dl_sum     out  8   checksum of written download bytes (see CONFIGURATION)
//  cpu_req    in   1   CPU read request, held until cpu_ack
//  cpu_addr   in   AW  CPU read address, stable while cpu_req
//  cpu_ack    out  1   one-cycle completion; cpu_data valid this cycle
//  cpu_data   out  8   read data, held until next CPU completion
//  hs_req     in   1   hiscore request, held until hs_ack
//  hs_we      in   1   1 = write, 0 = read; stable while hs_req
//  hs_addr    in   AW  hiscore address
//  hs_wdata   in   8   hiscore write data
//  hs_ack     out  1   one-cycle completion; hs_rdata valid this cycle (reads)
//  hs_rdata   out  8   hiscore read data, held
//  mem_addr   out  AW  memory address, registered
//  mem_we     out  1   memory write enable, registered
//  mem_wdata  out  8   memory write data, registered
//  mem_rdata  in   8   memory read data, valid 1 cycle after the address cycle
//  game_reset out  1   reset to dkong_top
// BEHAVIOUR
//  Reset: state IDLE; cpu_ack=hs_ack=mem_we=dl_ovf=0; cpu_data=hs_rdata=mem_addr=mem_wdata=0; dl_sum=0;
//   download buffer empty; last_grant=HS (CPU wins first tie); game_reset=1, hold counter loaded to HOLD_CYCLES.
//  Download buffer: 1 entry. dl_wr with dl_addr<MEM_DEPTH loads it (addr,data,pending=1); out-of-range
//   strobes are dropped silently. dl_wr while pending (and not being issued this cycle) sets dl_ovf, byte lost;
//   dl_ovf clears only on reset.
//  FSM IDLE -> ISSUE -> (DATA for reads) -> IDLE. Grant order in IDLE:
//   1) pending download write; 2) if dl_active=0: CPU/HS, round-robin via last_grant on simultaneous requests.
//   A requester whose ack is high this cycle is not eligible (prevents regrant on held req).
//  ISSUE: mem_addr/mem_we/mem_wdata valid for exactly one cycle; mem_we=1 only for download or hs_we=1.
//   Writes: ISSUE -> IDLE; download clears pending; HS write pulses hs_ack on the cycle after ISSUE.
//   Reads: ISSUE -> DATA; DATA captures mem_rdata into cpu_data/hs_rdata and pulses the matching ack next cycle.
//  Latency from req sampled high in IDLE: read ack +3 cycles, HS write ack +2, download write issued +1.
//  mem_we=0 in every state other than ISSUE-write.
//  dl_active rising mid-transaction: in-flight CPU/HS access completes and acks; new CPU/HS requests wait
//   (req stays pending, not dropped) until dl_active=0.
//  game_reset = reset | dl_active | (hold counter != 0). Counter reloads to HOLD_CYCLES while dl_active=1,
//   decrements to 0 after it falls.
//  Reset mid-operation: in-flight access abandoned, no ack, no mem_we in the following cycle.
// CONFIGURATION
//  `define DL_CHECKSUM_EN: dl_sum = mod-256 sum of bytes actually issued to memory in the current download;
//   cleared on dl_active rising edge, held after download ends. Without macro: dl_sum tied 8'h00, no adder.
// TESTING
//  1) Reset, cpu_req addr 16'h0010, mem holds 8'hA5 -> cpu_ack 3 cycles later with cpu_data=8'hA5, single pulse.
//  2) cpu_req & hs_req(read) same cycle, both held -> CPU acked first, HS acked next; repeat -> CPU, HS alternate.
//  3) dl_active=1, 4 strobes every 4 cycles bytes 01,02,03,FF -> 4 mem_we pulses, dl_ovf=0, dl_sum=8'h05 (EN).
//  4) dl_wr on consecutive cycles while buffer pending -> dl_ovf=1, second byte never written.
//  5) dl_active falls -> game_reset stays 1 for exactly HOLD_CYCLES=16 cycles then 0; dl_addr>=MEM_DEPTH -> no mem_we.
//  6) hs_req write in DATA of a CPU read, then reset asserted in ISSUE -> no hs_ack, mem_we=0 after reset.

Source files
------------

// File: rtl/dkong_mem_arbiter.sv
// Single-port memory arbiter: ROM download (absolute priority), CPU reads, hiscore read/write.
// Optional `define DL_CHECKSUM_EN enables the running download byte sum on dl_sum.
module dkong_mem_arbiter #(
    parameter int unsigned AW          = 16,
    parameter int unsigned MEM_DEPTH   = 65536,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          dl_active,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [7:0]    dl_data,
    output logic          dl_ovf,
    output logic [7:0]    dl_sum,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_ack,
    output logic [7:0]    cpu_data,
    input  logic          hs_req,
    input  logic          hs_we,
    input  logic [AW-1:0] hs_addr,
    input  logic [7:0]    hs_wdata,
    output logic          hs_ack,
    output logic [7:0]    hs_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic          game_reset
);
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StData} state_e;
    typedef enum logic [1:0] {GntDl, GntCpu, GntHs} gnt_e;

    state_e        state_q, state_d;
    gnt_e          gnt_q, gnt_d;
    logic          last_hs_q, last_hs_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;
    logic          cpu_ack_q, cpu_ack_d, hs_ack_q, hs_ack_d;
    logic [7:0]    cpu_data_q, cpu_data_d, hs_rdata_q, hs_rdata_d;
    logic          buf_pend_q, buf_pend_d;
    logic [AW-1:0] buf_addr_q, buf_addr_d;
    logic [7:0]    buf_data_q, buf_data_d;
    logic          dl_ovf_q, dl_ovf_d;
    logic [HW-1:0] hold_q, hold_d;

    logic dl_in_range, dl_issue, cpu_ok, hs_ok;

    assign dl_in_range = 64'(dl_addr) < 64'(MEM_DEPTH);
    assign dl_issue    = (state_q == StIssue) && (gnt_q == GntDl);
    // A requester still seeing its ack this cycle must not be regranted on its held req.
    assign cpu_ok      = cpu_req && !cpu_ack_q && !dl_active;
    assign hs_ok       = hs_req && !hs_ack_q && !dl_active;

    // One-entry download buffer; the slot frees when its ISSUE cycle completes.
    always_comb begin
        buf_pend_d = buf_pend_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        dl_ovf_d   = dl_ovf_q;
        if (dl_issue) buf_pend_d = 1'b0;
        if (dl_wr && dl_in_range) begin
            if (buf_pend_q && !dl_issue) begin
                dl_ovf_d = 1'b1;
            end else begin
                buf_pend_d = 1'b1;
                buf_addr_d = dl_addr;
                buf_data_d = dl_data;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_hs_d   = last_hs_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        cpu_ack_d   = 1'b0;
        hs_ack_d    = 1'b0;
        cpu_data_d  = cpu_data_q;
        hs_rdata_d  = hs_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (buf_pend_q) begin
                    gnt_d       = GntDl;
                    mem_addr_d  = buf_addr_q;
                    mem_wdata_d = buf_data_q;
                    mem_we_d    = 1'b1;
                    state_d     = StIssue;
                end else if (cpu_ok && (!hs_ok || last_hs_q)) begin
                    gnt_d      = GntCpu;
                    mem_addr_d = cpu_addr;
                    last_hs_d  = 1'b0;
                    state_d    = StIssue;
                end else if (hs_ok) begin
                    gnt_d       = GntHs;
                    mem_addr_d  = hs_addr;
                    mem_wdata_d = hs_wdata;
                    mem_we_d    = hs_we;
                    last_hs_d   = 1'b1;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (mem_we_q) begin
                    state_d  = StIdle;
                    hs_ack_d = (gnt_q == GntHs);
                end else begin
                    state_d = StData;
                end
            end
            StData: begin
                state_d = StIdle;
                if (gnt_q == GntCpu) begin
                    cpu_data_d = mem_rdata;
                    cpu_ack_d  = 1'b1;
                end else begin
                    hs_rdata_d = mem_rdata;
                    hs_ack_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        hold_d = hold_q;
        if (dl_active)         hold_d = HW'(HOLD_CYCLES);
        else if (hold_q != '0) hold_d = hold_q - HW'(1);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= StIdle;
            gnt_q       <= GntCpu;
            last_hs_q   <= 1'b1;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 8'h00;
            cpu_ack_q   <= 1'b0;
            hs_ack_q    <= 1'b0;
            cpu_data_q  <= 8'h00;
            hs_rdata_q  <= 8'h00;
            buf_pend_q  <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= 8'h00;
            dl_ovf_q    <= 1'b0;
            hold_q      <= HW'(HOLD_CYCLES);
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_hs_q   <= last_hs_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            hs_ack_q    <= hs_ack_d;
            cpu_data_q  <= cpu_data_d;
            hs_rdata_q  <= hs_rdata_d;
            buf_pend_q  <= buf_pend_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            dl_ovf_q    <= dl_ovf_d;
            hold_q      <= hold_d;
        end
    end

`ifdef DL_CHECKSUM_EN
    logic       dl_active_q;
    logic [7:0] dl_sum_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_active_q <= 1'b0;
            dl_sum_q    <= 8'h00;
        end else begin
            dl_active_q <= dl_active;
            if (dl_active && !dl_active_q) dl_sum_q <= 8'h00;
            else if (dl_issue)             dl_sum_q <= dl_sum_q + mem_wdata_q;
        end
    end

    assign dl_sum = dl_sum_q;
`else
    assign dl_sum = 8'h00;
`endif

    assign dl_ovf     = dl_ovf_q;
    assign cpu_ack    = cpu_ack_q;
    assign cpu_data   = cpu_data_q;
    assign hs_ack     = hs_ack_q;
    assign hs_rdata   = hs_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign game_reset = reset | dl_active | (hold_q != '0);

endmodule

// File: tb/tb_dkong_mem_arbiter.sv
// Directed bench for dkong_mem_arbiter with a synchronous byte-memory model behind it.
module tb_dkong_mem_arbiter;
    logic        clk_sys = 1'b0;
    logic        reset, dl_active, dl_wr, dl_ovf, cpu_req, cpu_ack, hs_req, hs_we, hs_ack;
    logic        mem_we, game_reset, tb_mem_clr;
    logic [15:0] dl_addr, cpu_addr, hs_addr, mem_addr;
    logic [7:0]  dl_data, dl_sum, cpu_data, hs_wdata, hs_rdata, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;
    int we_cnt;

    logic [7:0]   mem [0:511];
    logic [511:0] wr_valid;
    logic [7:0]   dl_bytes [4] = '{8'h01, 8'h02, 8'h03, 8'hFF};

    dkong_mem_arbiter #(.AW(16), .MEM_DEPTH(32768), .HOLD_CYCLES(16)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .dl_ovf(dl_ovf), .dl_sum(dl_sum),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_data(cpu_data),
        .hs_req(hs_req), .hs_we(hs_we), .hs_addr(hs_addr), .hs_wdata(hs_wdata),
        .hs_ack(hs_ack), .hs_rdata(hs_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .game_reset(game_reset)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] preload(input logic [15:0] a);
        case (a)
            16'h0010: return 8'hA5;
            16'h0020: return 8'h11;
            16'h0030: return 8'h22;
            default:  return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] peek(input logic [15:0] a);
        return wr_valid[a[8:0]] ? mem[a[8:0]] : preload(a);
    endfunction

    always @(posedge clk_sys) begin
        if (tb_mem_clr) begin
            wr_valid <= '0;
            we_cnt   <= 0;
        end else if (mem_we) begin
            mem[mem_addr[8:0]]      <= mem_wdata;
            wr_valid[mem_addr[8:0]] <= 1'b1;
            we_cnt                  <= we_cnt + 1;
        end
        mem_rdata <= peek(mem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int base, acks, gr_cnt;
        logic w1, w2;
        logic [7:0] got;
        logic [7:0] sum_exp;

        reset = 1'b1; tb_mem_clr = 1'b1;
        dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        cpu_req = 1'b0; cpu_addr = '0; hs_req = 1'b0; hs_we = 1'b0; hs_addr = '0; hs_wdata = '0;
        repeat (3) tick();
        chk("rst_cpu_ack", cpu_ack, 1'b0);
        chk("rst_hs_ack", hs_ack, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_dl_ovf", dl_ovf, 1'b0);
        chk("rst_cpu_data", cpu_data, 8'h00);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_dl_sum", dl_sum, 8'h00);
        chk("rst_game_reset", game_reset, 1'b1);
        reset = 1'b0; tb_mem_clr = 1'b0;

        // 1) CPU read: ack on the third edge, single pulse, no regrant while req held
        cpu_req = 1'b1; cpu_addr = 16'h0010;
        tick();
        chk("t1_issue_addr", mem_addr, 16'h0010);
        chk("t1_ack_early1", cpu_ack, 1'b0);
        tick();
        chk("t1_ack_early2", cpu_ack, 1'b0);
        tick();
        chk("t1_ack", cpu_ack, 1'b1);
        chk("t1_data", cpu_data, 8'hA5);
        tick();
        cpu_req = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            if (cpu_ack) acks++;
            tick();
        end
        chk("t1_no_regrant", acks, 0);

        // 2) simultaneous CPU/HS reads alternate, CPU first after reset
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        chk("t2_rst_cpu_data", cpu_data, 8'h00);
        cpu_req = 1'b1; cpu_addr = 16'h0020;
        hs_req = 1'b1; hs_we = 1'b0; hs_addr = 16'h0030;
        acks = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (cpu_ack || hs_ack) acks++;
            if (i == 3 || i == 9) begin
                chk("t2_cpu_turn", {cpu_ack, hs_ack}, 2'b10);
                chk("t2_cpu_data", cpu_data, 8'h11);
            end
            if (i == 6 || i == 12) begin
                chk("t2_hs_turn", {cpu_ack, hs_ack}, 2'b01);
                chk("t2_hs_data", hs_rdata, 8'h22);
            end
        end
        chk("t2_ack_count", acks, 4);
        cpu_req = 1'b0; hs_req = 1'b0;
        tick(); tick();

        // 2b) HS write: mem_we for one cycle, ack two edges after request
        hs_req = 1'b1; hs_we = 1'b1; hs_addr = 16'h0050; hs_wdata = 8'h3C;
        tick();
        chk("t2b_we", {mem_we, hs_ack}, 2'b10);
        tick();
        chk("t2b_ack", {mem_we, hs_ack}, 2'b01);
        hs_req = 1'b0; hs_we = 1'b0;
        tick();
        chk("t2b_mem", peek(16'h0050), 8'h3C);

        // 3) four spaced download strobes
        dl_active = 1'b1;
        tick();
        chk("t3_game_reset", game_reset, 1'b1);
        base = we_cnt;
        for (int i = 0; i < 4; i++) begin
            dl_addr = 16'h0100 + 16'(i); dl_data = dl_bytes[i]; dl_wr = 1'b1;
            tick(); w1 = mem_we; dl_wr = 1'b0;
            tick(); w2 = mem_we;
            tick(); tick();
            chk("t3_issue_latency", {w1, w2}, 2'b01);
        end
        chk("t3_we_count", we_cnt - base, 4);
        chk("t3_ovf", dl_ovf, 1'b0);
        chk("t3_mem0", peek(16'h0100), 8'h01);
        chk("t3_mem3", peek(16'h0103), 8'hFF);
`ifdef DL_CHECKSUM_EN
        sum_exp = 8'h05;
`else
        sum_exp = 8'h00;
`endif
        chk("t3_sum", dl_sum, sum_exp);

        // 4) back-to-back strobes while the buffer is pending: second byte lost
        base = we_cnt;
        dl_addr = 16'h0200; dl_data = 8'h77; dl_wr = 1'b1;
        tick();
        dl_addr = 16'h0201; dl_data = 8'h88;
        tick();
        dl_wr = 1'b0;
        repeat (4) tick();
        chk("t4_ovf", dl_ovf, 1'b1);
        chk("t4_we_count", we_cnt - base, 1);
        chk("t4_mem_first", peek(16'h0200), 8'h77);
        chk("t4_mem_lost", peek(16'h0201), 8'h00);
`ifdef DL_CHECKSUM_EN
        sum_exp = 8'h7C;
`endif
        chk("t4_sum", dl_sum, sum_exp);

        // 5) address range boundary, CPU held off by download, reset hold
        base = we_cnt;
        dl_addr = 16'h8000; dl_data = 8'h99; dl_wr = 1'b1;
        tick(); dl_wr = 1'b0;
        repeat (4) tick();
        chk("t5_out_of_range", we_cnt - base, 0);
        dl_addr = 16'h7FFF; dl_data = 8'h42; dl_wr = 1'b1;
        tick(); dl_wr = 1'b0;
        repeat (4) tick();
        chk("t5_last_in_range", we_cnt - base, 1);
        chk("t5_mem_last", peek(16'h7FFF), 8'h42);
        cpu_req = 1'b1; cpu_addr = 16'h0200;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (cpu_ack) acks++;
        end
        chk("t5_cpu_waits", acks, 0);
        dl_active = 1'b0;
        #1;
        gr_cnt = 0; got = 8'h00;
        for (int i = 0; i < 20; i++) begin
            if (game_reset) gr_cnt++;
            if (cpu_ack) begin
                acks++;
                got = cpu_data;
                cpu_req = 1'b0;
            end
            tick();
        end
        chk("t5_hold_cycles", gr_cnt, 16);
        chk("t5_game_reset_low", game_reset, 1'b0);
        chk("t5_cpu_served", acks, 1);
        chk("t5_cpu_data", got, 8'h77);
`ifdef DL_CHECKSUM_EN
        sum_exp = 8'hBE;
`endif
        chk("t5_sum_held", dl_sum, sum_exp);

        // 6) HS write queued behind a CPU read, then reset during its ISSUE
        cpu_req = 1'b1; cpu_addr = 16'h0010;
        tick(); tick();
        hs_req = 1'b1; hs_we = 1'b1; hs_addr = 16'h0040; hs_wdata = 8'h5A;
        tick();
        chk("t6_cpu_ack", cpu_ack, 1'b1);
        cpu_req = 1'b0;
        tick();
        chk("t6_hs_issue", {mem_we, mem_addr}, {1'b1, 16'h0040});
        reset = 1'b1;
        tick();
        chk("t6_after_reset", {hs_ack, mem_we, game_reset}, 3'b001);
        hs_req = 1'b0; hs_we = 1'b0;
        tick();
        reset = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            if (hs_ack) acks++;
            tick();
        end
        chk("t6_no_hs_ack", acks, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
